// File: rtl/tmds_encoder_dc.sv
// tmds_encoder_dc: DVI 8b/10b transition-minimising, DC-balanced TMDS encoder.
// Each channel keeps its own running disparity; the pipeline latency is two clocks.
module tmds_encoder_dc #(
    parameter int CHANNELS    = 3,
    parameter int COLOUR_BITS = 3
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            blank,
    input  logic [2*CHANNELS-1:0]           ctl,
    input  logic [CHANNELS*COLOUR_BITS-1:0] pixel,
    output logic [10*CHANNELS-1:0]          symbols,
    output logic [9:0]                      clk_symbol
);
    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    logic blank_q;

    assign clk_symbol = 10'b0000011111;

    always_ff @(posedge clk) begin
        if (!reset_n) blank_q <= 1'b1;
        else          blank_q <= blank;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [7:0]        d;
        logic [3:0]        n1, n1q;
        logic              flip;
        logic [8:0]        qm, qm_q;
        logic [1:0]        ctl_q;
        logic signed [4:0] cnt, cnt_nx, disp;
        logic [9:0]        sym, sym_nx;

        // MSB-first replication of the colour value out to eight bits
        for (genvar k = 0; k < 8; k++) begin : g_w
            assign d[7-k] = pixel[c*COLOUR_BITS + COLOUR_BITS - 1 - (k % COLOUR_BITS)];
        end

        assign n1 = 4'($countones(d));

        always_comb begin
            flip  = n1 > 4'd4 || (n1 == 4'd4 && !d[0]);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++)
                qm[i] = flip ? ~(qm[i-1] ^ d[i]) : qm[i-1] ^ d[i];
            qm[8] = !flip;
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                ctl_q <= 2'b00;
                qm_q  <= '0;
            end else begin
                ctl_q <= ctl[2*c +: 2];
                qm_q  <= qm;
            end
        end

        // disp = ones - zeros of q_m[7:0]; wraps correctly at n1q == 8
        assign n1q  = 4'($countones(qm_q[7:0]));
        assign disp = $signed({n1q, 1'b0}) - 5'sd8;

        always_comb begin
            sym_nx = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_nx = qm_q[8] ? cnt + disp : cnt - disp;
            if (blank_q) begin
                sym_nx = ctl_q == 2'b00 ? CTL_00 :
                         ctl_q == 2'b01 ? CTL_01 :
                         ctl_q == 2'b10 ? CTL_10 : CTL_11;
                cnt_nx = 5'sd0;
            end else if (cnt != 5'sd0 && n1q != 4'd4) begin
                if (cnt[4] == disp[4]) begin
                    sym_nx = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_nx = cnt - disp + (qm_q[8] ? 5'sd2 : 5'sd0);
                end else begin
                    sym_nx = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_nx = cnt + disp - (qm_q[8] ? 5'sd0 : 5'sd2);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sym <= CTL_00;
                cnt <= 5'sd0;
            end else begin
                sym <= sym_nx;
                cnt <= cnt_nx;
            end
        end

        assign symbols[10*c +: 10] = sym;
    end
endmodule

// File: tb/tb_tmds_encoder_dc.sv
// tb_tmds_encoder_dc: four encoder configurations driven in lockstep against a
// per-channel reference model through a scoreboard queue, plus a vector table.
module tb_tmds_encoder_dc;
    localparam int NCH = 11;
    localparam int CB [NCH] = '{8, 8, 8, 3, 3, 3, 1, 1, 1, 1, 1};
    localparam logic [9:0] C00 = 10'b1101010100;

    typedef struct packed {
        logic                     blk;
        logic [NCH-1:0][9:0]      s;
        logic [NCH-1:0][7:0]      d;
        logic [NCH-1:0][4:0]      cnt;
        logic                     tchk;
        logic [9:0]               t0, t1, t3;
    } exp_t;

    typedef struct packed {
        logic       rn, blk;
        logic [7:0] p;
        logic [1:0] c;
        logic       chk;
        logic [9:0] e0, e1, e3;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic blank = 1'b1;
    logic [7:0] px [NCH];
    logic [1:0] cx [NCH];
    logic [9:0] sy [NCH];
    logic [23:0] p8;
    logic [8:0]  p3;
    logic        p1;
    logic [3:0]  p4;
    logic [5:0]  c8, c3;
    logic [1:0]  c1;
    logic [7:0]  c4;
    logic [29:0] s8, s3;
    logic [9:0]  s1;
    logic [39:0] s4;
    logic [9:0]  k8, k3, k1, k4;

    exp_t sb [$];
    vec_t tbl [18];
    int mcnt [NCH];
    int rd [NCH];
    int tests = 0;
    int fails = 0;
    logic tchk_c;
    logic [9:0] t0_c, t1_c, t3_c;

    always #5 clk = ~clk;

    assign p8 = {px[2], px[1], px[0]};
    assign p3 = {px[5][2:0], px[4][2:0], px[3][2:0]};
    assign p1 = px[6][0];
    assign p4 = {px[10][0], px[9][0], px[8][0], px[7][0]};
    assign c8 = {cx[2], cx[1], cx[0]};
    assign c3 = {cx[5], cx[4], cx[3]};
    assign c1 = cx[6];
    assign c4 = {cx[10], cx[9], cx[8], cx[7]};
    assign sy[0]  = s8[9:0];
    assign sy[1]  = s8[19:10];
    assign sy[2]  = s8[29:20];
    assign sy[3]  = s3[9:0];
    assign sy[4]  = s3[19:10];
    assign sy[5]  = s3[29:20];
    assign sy[6]  = s1;
    assign sy[7]  = s4[9:0];
    assign sy[8]  = s4[19:10];
    assign sy[9]  = s4[29:20];
    assign sy[10] = s4[39:30];

    tmds_encoder_dc #(.CHANNELS(3), .COLOUR_BITS(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .blank(blank), .ctl(c8), .pixel(p8),
        .symbols(s8), .clk_symbol(k8));
    tmds_encoder_dc #(.CHANNELS(3), .COLOUR_BITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .blank(blank), .ctl(c3), .pixel(p3),
        .symbols(s3), .clk_symbol(k3));
    tmds_encoder_dc #(.CHANNELS(1), .COLOUR_BITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .blank(blank), .ctl(c1), .pixel(p1),
        .symbols(s1), .clk_symbol(k1));
    tmds_encoder_dc #(.CHANNELS(4), .COLOUR_BITS(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .blank(blank), .ctl(c4), .pixel(p4),
        .symbols(s4), .clk_symbol(k4));

    function automatic logic [7:0] widen(input logic [7:0] p, input int cb);
        logic [63:0] t = '0;
        for (int i = 0; i < 8; i++) t = (t << cb) | 64'(p & 8'((1 << cb) - 1));
        return 8'(t >> (8 * cb - 8));
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] m, r;
        m = s[9] ? ~s[7:0] : s[7:0];
        r[0] = m[0];
        for (int k = 1; k < 8; k++) r[k] = s[8] ? m[k] ^ m[k-1] : ~(m[k] ^ m[k-1]);
        return r;
    endfunction

    task automatic model(input int ch, input logic [7:0] d, input logic b,
                         input logic [1:0] c, output logic [9:0] s);
        int n1, n1q, q8;
        logic xn;
        logic [8:0] qm;
        if (b) begin
            s = ctl_sym(c);
            mcnt[ch] = 0;
        end else begin
            n1 = $countones(d);
            xn = n1 > 4 || (n1 == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int k = 1; k < 8; k++) qm[k] = xn ? ~(qm[k-1] ^ d[k]) : qm[k-1] ^ d[k];
            q8 = xn ? 0 : 1;
            qm[8] = q8[0];
            n1q = $countones(qm[7:0]);
            if (mcnt[ch] == 0 || n1q == 4) begin
                s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                mcnt[ch] += q8 == 1 ? 2 * n1q - 8 : 8 - 2 * n1q;
            end else if ((mcnt[ch] > 0 && n1q > 4) || (mcnt[ch] < 0 && n1q < 4)) begin
                s = {1'b1, qm[8], ~qm[7:0]};
                mcnt[ch] += 2 * q8 + 8 - 2 * n1q;
            end else begin
                s = {1'b0, qm[8], qm[7:0]};
                mcnt[ch] += 2 * n1q - 8 - 2 * (1 - q8);
            end
        end
    endtask

    task automatic check(input string name, input int ch,
                         input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s ch%0d got %0d expected %0d", name, ch, act, exp);
        end
    endtask

    task automatic cycle();
        exp_t e;
        logic [9:0] s;
        logic [7:0] d;
        e = '0;
        e.tchk = tchk_c;
        e.t0 = t0_c;
        e.t1 = t1_c;
        e.t3 = t3_c;
        if (!reset_n) begin
            sb.delete();
            e.blk = 1'b1;
            for (int ch = 0; ch < NCH; ch++) begin
                e.s[ch] = C00;
                mcnt[ch] = 0;
            end
            sb.push_back(e);
            sb.push_back(e);
        end else begin
            e.blk = blank;
            for (int ch = 0; ch < NCH; ch++) begin
                d = widen(px[ch], CB[ch]);
                model(ch, d, blank, cx[ch], s);
                e.s[ch] = s;
                e.d[ch] = d;
                e.cnt[ch] = 5'(mcnt[ch]);
            end
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard empty got 0 expected 1");
        end else begin
            e = sb.pop_front();
            for (int ch = 0; ch < NCH; ch++) begin
                check("symbol", ch, 32'(sy[ch]), 32'(e.s[ch]));
                if (e.blk) rd[ch] = 0;
                else begin
                    rd[ch] += 2 * $countones(sy[ch]) - 10;
                    check("decode", ch, 32'(decode(sy[ch])), 32'(e.d[ch]));
                    check("disparity", ch, rd[ch], 32'($signed(e.cnt[ch])));
                    check("disparity_bound", ch, (rd[ch] >= -8 && rd[ch] <= 8) ? 1 : 0, 1);
                end
            end
            if (e.tchk) begin
                check("table_ch0", 0, 32'(sy[0]), 32'(e.t0));
                check("table_ch1", 1, 32'(sy[1]), 32'(e.t1));
                check("table_cb3_ch0", 3, 32'(sy[3]), 32'(e.t3));
            end
        end
    endtask

    initial begin
        //            rn    blk   p      c      chk   ch0      ch1      cb3 ch0
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354, 10'h354, 10'h354};
        tbl[1]  = '{1'b1, 1'b1, 8'h00, 2'b01, 1'b1, 10'h0AB, 10'h354, 10'h0AB};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h100, 10'h100, 10'h100};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h100, 10'h100, 10'h100};
        tbl[5]  = '{1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354, 10'h354, 10'h354};
        tbl[6]  = '{1'b1, 1'b0, 8'hFF, 2'b00, 1'b1, 10'h200, 10'h200, 10'h200};
        tbl[7]  = '{1'b1, 1'b1, 8'h00, 2'b10, 1'b1, 10'h154, 10'h354, 10'h154};
        tbl[8]  = '{1'b1, 1'b0, 8'hFF, 2'b00, 1'b1, 10'h200, 10'h200, 10'h200};
        tbl[9]  = '{1'b1, 1'b1, 8'h00, 2'b11, 1'b1, 10'h2AB, 10'h354, 10'h2AB};
        tbl[10] = '{1'b1, 1'b0, 8'h05, 2'b00, 1'b1, 10'h103, 10'h103, 10'h2C7};
        tbl[11] = '{1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354, 10'h354, 10'h354};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h100, 10'h100, 10'h100};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF};
        tbl[14] = '{1'b0, 1'b0, 8'hFF, 2'b00, 1'b1, 10'h354, 10'h354, 10'h354};
        tbl[15] = '{1'b1, 1'b0, 8'hFF, 2'b00, 1'b1, 10'h200, 10'h200, 10'h200};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF};
        tbl[17] = '{1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354, 10'h354, 10'h354};
        for (int ch = 0; ch < NCH; ch++) begin
            px[ch] = 8'h00;
            cx[ch] = 2'b00;
            mcnt[ch] = 0;
            rd[ch] = 0;
        end
        tchk_c = 1'b0;
        t0_c = '0;
        t1_c = '0;
        t3_c = '0;
        @(negedge clk);
        check("clk_symbol_reset", 0, 32'(k8), 32'h01F);
        check("clk_symbol_reset", 3, 32'(k3), 32'h01F);
        for (int i = 0; i < 18; i++) begin
            reset_n = tbl[i].rn;
            blank = tbl[i].blk;
            for (int ch = 0; ch < NCH; ch++) begin
                px[ch] = tbl[i].p;
                cx[ch] = (ch == 0 || ch == 3) ? tbl[i].c : 2'b00;
            end
            tchk_c = tbl[i].chk;
            t0_c = tbl[i].e0;
            t1_c = tbl[i].e1;
            t3_c = tbl[i].e3;
            cycle();
        end
        tchk_c = 1'b0;
        reset_n = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            blank = $urandom_range(0, 4) == 0;
            for (int ch = 0; ch < NCH; ch++) begin
                px[ch] = 8'($urandom_range(0, 255));
                cx[ch] = 2'($urandom_range(0, 3));
            end
            cycle();
        end
        blank = 1'b1;
        cycle();
        check("clk_symbol", 6, 32'(k1), 32'h01F);
        check("clk_symbol", 7, 32'(k4), 32'h01F);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tmds_encoder_dc.md
Name: tmds_encoder_dc

Overview:
- Pixel-clock TMDS encoder for the DVI/HDMI output path. Supersedes the fixed lookup-table symbol generator with the full DVI 1.0 8b/10b transition-minimising, DC-balanced algorithm.
- Channel count and colour depth are parametrised. Each channel keeps its own running-disparity counter.
- Output symbols feed the existing clkx5 serialiser/DDR pad logic unchanged. Bit 0 is transmitted first.

Parameters:
- CHANNELS, 3, number of TMDS data channels (1..4); channel 0 is blue, 1 green, 2 red.
- COLOUR_BITS, 3, bits per channel of input colour (1..8); widened to 8 bits by MSB-first bit replication.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- blank  in  1  1 = control period, 0 = active video
- ctl  in  2*CHANNELS  per-channel {C1,C0}; channel 0 carries {vsync,hsync}
- pixel  in  CHANNELS*COLOUR_BITS  colour per channel, channel i at [i*COLOUR_BITS +: COLOUR_BITS]
- symbols  out  10*CHANNELS  encoded symbol per channel, channel i at [i*10 +: 10]
- clk_symbol  out  1*10  constant 10'b0000011111

Behaviour:
- Pipeline latency: 2 clk. Inputs sampled on cycle N produce symbols valid after edge N+2. No stalls; one symbol per channel per clk.
- Widening: D[7:0] = first 8 bits of {p,p,p,...} (MSB first). Example: COLOUR_BITS=3, p=3'b101 -> 8'b10110110. COLOUR_BITS=8 passes through.
- Stage 1 (registered): N1 = popcount(D).
  - If N1>4 or (N1==4 and D[0]==0): XNOR chain, q_m[0]=D[0], q_m[k]=~(q_m[k-1]^D[k]), q_m[8]=0.
  - Else: XOR chain, q_m[8]=1.
  - blank and ctl are delayed alongside.
- Stage 2 (registered), cnt is a signed 5-bit per-channel register, N1q = popcount(q_m[7:0]), N0q = 8-N1q:
  - If cnt==0 or N1q==N0q: q[9]=~q_m[8], q[8]=q_m[8], q[7:0] = q_m[8] ? q_m : ~q_m. cnt += q_m[8] ? (N1q-N0q) : (N0q-N1q).
  - Else if (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q): q[9]=1, q[8]=q_m[8], q[7:0]=~q_m. cnt += 2*q_m[8] + (N0q-N1q).
  - Else: q[9]=0, q[8]=q_m[8], q[7:0]=q_m. cnt += (N1q-N0q) - 2*(~q_m[8]).
- Control period (delayed blank=1): symbol from delayed ctl, vector notation [9:0]:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
  - cnt forced to 0 on every blank cycle.
- cnt always stays within -8..+8. No saturation logic is needed; the range must hold by construction.
- Reset (reset_n=0 at clk edge):
  - All pipeline registers load blank=1, ctl=00.
  - cnt=0.
  - symbols = 1101010100 on every channel from the next edge. Reset mid-line overrides any data in flight.
  - After release, the first data-derived symbol appears 2 edges after the first sampled input.
- Blank→active transition: first active symbol uses cnt=0. Active→blank: control symbol appears exactly 2 cycles after blank rises; no data symbols are dropped or duplicated.
- clk_symbol is combinational constant, unaffected by reset.

Test Plan:
- Reset, then blank=1, ctl ch0=01, others 00 -> after 2 clk ch0=0010101011, ch1/ch2=1101010100.
- COLOUR_BITS=8, blank=0, ch0 pixel 0x00 for 3 cycles from cnt=0 -> ch0 symbols 0x100, 0x3FF, 0x100; internal cnt -8, +2, -6.
- COLOUR_BITS=8, pixel 0xFF from cnt=0 -> 0x200, cnt=-8. Then blank one cycle -> control symbol, cnt=0. Then 0xFF again -> 0x200.
- COLOUR_BITS=3, pixel 3'b101 -> D=0xB6 -> symbols match a software reference model over 1000 random pixels/blanks. The bench must also check running disparity of emitted bits stays within ±8 and every data symbol decodes back to D.
- Assert reset_n=0 for 1 cycle mid-active-line with non-zero cnt -> next symbols 1101010100 on all channels, cnt=0, then 2-cycle latency to first data symbol after release.
- Parametric sweep CHANNELS=1 and 4, COLOUR_BITS=1 (p=1 -> 0xFF, p=0 -> 0x00) -> per-channel results independent and identical to single-channel model.
